// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU LSU (port 0) and a debug/DMA loader (port 1).
// Optional access legality check is enabled by defining DMEM_ARB_ALIGN_CHK_EN.
module dmem_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        p0_req,
    output logic        p0_ready,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [2:0]  p0_memop,
    input  logic        p0_we,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    output logic        p1_ready,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [2:0]  p1_memop,
    input  logic        p1_we,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_datain,
    output logic [2:0]  mem_memop,
    output logic        mem_we,
    input  logic [31:0] mem_dataout
);

    localparam logic [2:0] MEMOP_IDLE = 3'b010;
    localparam logic [1:0] LOAD_CNT   = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q;
    logic        owner_q;
    logic        last_q;
    logic        we_q;
    logic [1:0]  cnt_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_datain_q;
    logic [2:0]  mem_memop_q;
    logic        mem_we_q;
    logic [1:0]  rvalid_q;
    logic [1:0]  err_q;
    logic [31:0] rdata_q [2];

    logic        grant_d;
    logic        accept_d;
    logic        illegal_d;
    logic [31:0] sel_addr_d;
    logic [31:0] sel_wdata_d;
    logic [2:0]  sel_memop_d;
    logic        sel_we_d;

`ifdef DMEM_ARB_ALIGN_CHK_EN
    function automatic logic access_illegal(input logic [2:0] op, input logic [1:0] a);
        logic bad;
        case (op)
            3'b001, 3'b101:         bad = a[0];
            3'b010:                 bad = (a != 2'b00);
            3'b011, 3'b110, 3'b111: bad = 1'b1;
            default:                bad = 1'b0;
        endcase
        return bad;
    endfunction
`endif

    // On a tie the port that was not served last wins.
    always_comb begin
        grant_d = 1'b0;
        if (p0_req && p1_req) begin
            grant_d = ~last_q;
        end else if (p1_req) begin
            grant_d = 1'b1;
        end
    end

    assign accept_d    = (state_q == IDLE) && (p0_req || p1_req);
    assign p0_ready    = (state_q == IDLE) && p0_req && !grant_d;
    assign p1_ready    = (state_q == IDLE) && p1_req && grant_d;

    assign sel_addr_d  = grant_d ? p1_addr  : p0_addr;
    assign sel_wdata_d = grant_d ? p1_wdata : p0_wdata;
    assign sel_memop_d = grant_d ? p1_memop : p0_memop;
    assign sel_we_d    = grant_d ? p1_we    : p0_we;

`ifdef DMEM_ARB_ALIGN_CHK_EN
    assign illegal_d = access_illegal(sel_memop_d, sel_addr_d[1:0]);
`else
    assign illegal_d = 1'b0;
`endif

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            we_q         <= 1'b0;
            cnt_q        <= 2'd0;
            mem_addr_q   <= 32'd0;
            mem_datain_q <= 32'd0;
            mem_memop_q  <= MEMOP_IDLE;
            mem_we_q     <= 1'b0;
            rvalid_q     <= 2'b00;
            err_q        <= 2'b00;
            rdata_q[0]   <= 32'd0;
            rdata_q[1]   <= 32'd0;
        end else begin
            rvalid_q <= 2'b00;
            err_q    <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        owner_q <= grant_d;
                        last_q  <= grant_d;
                        if (illegal_d) begin
                            // Rejected accesses never touch the memory bus.
                            state_q           <= RESP;
                            rvalid_q[grant_d] <= 1'b1;
                            err_q[grant_d]    <= 1'b1;
                            rdata_q[grant_d]  <= 32'd0;
                        end else begin
                            state_q      <= ACCESS;
                            mem_addr_q   <= sel_addr_d;
                            mem_datain_q <= sel_wdata_d;
                            mem_memop_q  <= sel_memop_d;
                            mem_we_q     <= sel_we_d;
                            we_q         <= sel_we_d;
                            cnt_q        <= sel_we_d ? 2'd0 : LOAD_CNT;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == 2'd0) begin
                        state_q           <= RESP;
                        rvalid_q[owner_q] <= 1'b1;
                        rdata_q[owner_q]  <= we_q ? 32'd0 : mem_dataout;
                        mem_we_q          <= 1'b0;
                        mem_memop_q       <= MEMOP_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_datain = mem_datain_q;
    assign mem_memop  = mem_memop_q;
    assign mem_we     = mem_we_q;
    assign p0_rvalid  = rvalid_q[0];
    assign p1_rvalid  = rvalid_q[1];
    assign p0_err     = err_q[0];
    assign p1_err     = err_q[1];
    assign p0_rdata   = rdata_q[0];
    assign p1_rdata   = rdata_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with RD_LAT=1 and one with RD_LAT=3, each on a small memory model.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clock = ~clock;

    // Instance A (RD_LAT=1)
    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic [2:0]  p0_memop = 0, p1_memop = 0;
    logic        p0_ready, p0_rvalid, p0_err, p1_ready, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_datain, mem_dataout;
    logic [2:0]  mem_memop;
    logic        mem_we;

    // Instance B (RD_LAT=3), only port 0 is exercised
    logic        q0_req = 0, q0_we = 0, q1_req = 0, q1_we = 0;
    logic [31:0] q0_addr = 0, q0_wdata = 0, q1_addr = 0, q1_wdata = 0;
    logic [2:0]  q0_memop = 0, q1_memop = 0;
    logic        q0_ready, q0_rvalid, q0_err, q1_ready, q1_rvalid, q1_err;
    logic [31:0] q0_rdata, q1_rdata;
    logic [31:0] mem_addr_b, mem_datain_b, mem_dataout_b;
    logic [2:0]  mem_memop_b;
    logic        mem_we_b;

    dmem_arbiter #(.RD_LAT(1)) u_dut (
        .clock(clock), .rst_n(rst_n),
        .p0_req(p0_req), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_memop(p0_memop), .p0_we(p0_we), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_memop(p1_memop), .p1_we(p1_we), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_memop(mem_memop), .mem_we(mem_we),
        .mem_dataout(mem_dataout)
    );

    dmem_arbiter #(.RD_LAT(3)) u_dut3 (
        .clock(clock), .rst_n(rst_n),
        .p0_req(q0_req), .p0_ready(q0_ready), .p0_addr(q0_addr), .p0_wdata(q0_wdata),
        .p0_memop(q0_memop), .p0_we(q0_we), .p0_rvalid(q0_rvalid), .p0_rdata(q0_rdata), .p0_err(q0_err),
        .p1_req(q1_req), .p1_ready(q1_ready), .p1_addr(q1_addr), .p1_wdata(q1_wdata),
        .p1_memop(q1_memop), .p1_we(q1_we), .p1_rvalid(q1_rvalid), .p1_rdata(q1_rdata), .p1_err(q1_err),
        .mem_addr(mem_addr_b), .mem_datain(mem_datain_b), .mem_memop(mem_memop_b), .mem_we(mem_we_b),
        .mem_dataout(mem_dataout_b)
    );

    // data_mem-style extension of a read word according to memop and byte offset
    function automatic logic [31:0] mem_read(input logic [31:0] w, input logic [1:0] a, input logic [2:0] op);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (op)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    logic [31:0] mem_a [0:63];
    initial begin
        for (int i = 0; i < 64; i++) mem_a[i] = 32'd0;
        mem_a[0] = 32'h1111_1111;
        mem_a[1] = 32'h2222_2222;
        mem_a[4] = 32'hDEAD_BEEF;
    end

    always @(posedge clock) begin
        if (mem_we) begin
            case (mem_memop)
                3'b000:  mem_a[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_datain[7:0];
                3'b001:  mem_a[mem_addr[7:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_datain[15:0];
                default: mem_a[mem_addr[7:2]] <= mem_datain;
            endcase
        end
    end

    assign mem_dataout = mem_read(mem_a[mem_addr[7:2]], mem_addr[1:0], mem_memop);

    logic [31:0] rdb_comb, pipe_b0 = 32'd0, pipe_b1 = 32'd0;
    assign rdb_comb = mem_read((mem_addr_b[31:2] == 30'd0) ? 32'h8001_0000 : 32'd0,
                               mem_addr_b[1:0], mem_memop_b);
    always @(posedge clock) begin
        pipe_b0 <= rdb_comb;
        pipe_b1 <= pipe_b0;
    end
    assign mem_dataout_b = pipe_b1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        check_eq("rst_p0_ready", {31'd0, p0_ready}, 0);
        check_eq("rst_p1_rvalid", {31'd0, p1_rvalid}, 0);
        check_eq("rst_p0_err", {31'd0, p0_err}, 0);
        check_eq("rst_p0_rdata", p0_rdata, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_memop", {29'd0, mem_memop}, 32'h2);
        check_eq("rst_mem_we", {31'd0, mem_we}, 0);
        rst_n = 1'b1;
        tick();

        // p0 lw 0x10
        p0_req = 1; p0_addr = 32'h10; p0_memop = 3'b010; p0_we = 0;
        #1;
        check_eq("t1_p0_ready", {31'd0, p0_ready}, 1);
        check_eq("t1_p1_ready", {31'd0, p1_ready}, 0);
        tick();
        p0_req = 0;
        check_eq("t1_acc_addr", mem_addr, 32'h10);
        check_eq("t1_acc_rvalid", {31'd0, p0_rvalid}, 0);
        tick();
        check_eq("t1_p0_rvalid", {31'd0, p0_rvalid}, 1);
        check_eq("t1_p0_rdata", p0_rdata, 32'hDEAD_BEEF);
        check_eq("t1_p1_rvalid", {31'd0, p1_rvalid}, 0);
        check_eq("t1_p0_err", {31'd0, p0_err}, 0);
        tick();
        check_eq("t1_rvalid_drop", {31'd0, p0_rvalid}, 0);
        check_eq("t1_rdata_hold", p0_rdata, 32'hDEAD_BEEF);
        check_eq("t1_idle_memop", {29'd0, mem_memop}, 32'h2);

        // p1 sb 0xA5 @0x23 then lbu
        p1_req = 1; p1_addr = 32'h23; p1_wdata = 32'h0000_00A5; p1_memop = 3'b000; p1_we = 1;
        #1;
        check_eq("t2_p1_ready", {31'd0, p1_ready}, 1);
        tick();
        p1_req = 0;
        check_eq("t2_we_hi", {31'd0, mem_we}, 1);
        check_eq("t2_memop", {29'd0, mem_memop}, 0);
        check_eq("t2_datain", mem_datain, 32'hA5);
        tick();
        check_eq("t2_we_lo", {31'd0, mem_we}, 0);
        check_eq("t2_p1_rvalid", {31'd0, p1_rvalid}, 1);
        check_eq("t2_p1_rdata", p1_rdata, 0);
        tick();
        p1_req = 1; p1_memop = 3'b100; p1_we = 0;
        #1;
        check_eq("t2b_p1_ready", {31'd0, p1_ready}, 1);
        tick();
        p1_req = 0;
        check_eq("t2b_we", {31'd0, mem_we}, 0);
        tick();
        check_eq("t2b_p1_rvalid", {31'd0, p1_rvalid}, 1);
        check_eq("t2b_p1_rdata", p1_rdata, 32'hA5);
        tick();

        // Both ports requesting continuously
        p0_req = 1; p0_addr = 32'h0; p0_memop = 3'b010; p0_we = 0;
        p1_req = 1; p1_addr = 32'h4; p1_memop = 3'b010; p1_we = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_eq("rr_p0_ready", {31'd0, p0_ready}, (i % 2 == 0) ? 1 : 0);
            check_eq("rr_p1_ready", {31'd0, p1_ready}, (i % 2 == 1) ? 1 : 0);
            tick();
            check_eq("rr_acc_ready", {31'd0, p0_ready | p1_ready}, 0);
            tick();
            check_eq("rr_p0_rvalid", {31'd0, p0_rvalid}, (i % 2 == 0) ? 1 : 0);
            check_eq("rr_p1_rvalid", {31'd0, p1_rvalid}, (i % 2 == 1) ? 1 : 0);
            if (i % 2 == 0) check_eq("rr_p0_rdata", p0_rdata, 32'h1111_1111);
            else            check_eq("rr_p1_rdata", p1_rdata, 32'h2222_2222);
            tick();
        end
        p0_req = 0; p1_req = 0;

        // p0 lw at misaligned 0x6
        p0_req = 1; p0_addr = 32'h6; p0_memop = 3'b010; p0_we = 0;
        #1;
        check_eq("t4_p0_ready", {31'd0, p0_ready}, 1);
        tick();
        p0_req = 0;
        check_eq("t4_we0", {31'd0, mem_we}, 0);
`ifdef DMEM_ARB_ALIGN_CHK_EN
        check_eq("t4_rvalid", {31'd0, p0_rvalid}, 1);
        check_eq("t4_err", {31'd0, p0_err}, 1);
        check_eq("t4_rdata", p0_rdata, 0);
        tick();
        check_eq("t4_rvalid_drop", {31'd0, p0_rvalid}, 0);
        check_eq("t4_we1", {31'd0, mem_we}, 0);
`else
        check_eq("t4_acc_addr", mem_addr, 32'h6);
        check_eq("t4_acc_rvalid", {31'd0, p0_rvalid}, 0);
        tick();
        check_eq("t4_rvalid", {31'd0, p0_rvalid}, 1);
        check_eq("t4_err", {31'd0, p0_err}, 0);
        check_eq("t4_rdata", p0_rdata, 32'h2222_2222);
        tick();
`endif

        // RD_LAT=3 lh at 0x2 on instance B
        q0_req = 1; q0_addr = 32'h2; q0_memop = 3'b001; q0_we = 0;
        #1;
        check_eq("t5_q0_ready", {31'd0, q0_ready}, 1);
        check_eq("t5_q1_ready", {31'd0, q1_ready}, 0);
        tick();
        q0_req = 0;
        for (int i = 0; i < 3; i++) begin
            check_eq("t5_rvalid_early", {31'd0, q0_rvalid}, 0);
            tick();
        end
        check_eq("t5_rvalid", {31'd0, q0_rvalid}, 1);
        check_eq("t5_rdata", q0_rdata, 32'hFFFF_8001);
        check_eq("t5_err", {31'd0, q0_err}, 0);
        check_eq("t5_q1_idle", {30'd0, q1_rvalid, q1_err}, 0);
        check_eq("t5_q1_rdata", q1_rdata, 0);
        check_eq("t5_b_we", {31'd0, mem_we_b}, 0);
        check_eq("t5_b_datain", mem_datain_b, 0);
        tick();

        // Reset during ACCESS of p1 sw
        p1_req = 1; p1_addr = 32'h30; p1_wdata = 32'h1234_5678; p1_memop = 3'b010; p1_we = 1;
        #1;
        check_eq("t6_p1_ready", {31'd0, p1_ready}, 1);
        tick();
        p1_req = 0;
        check_eq("t6_we_hi", {31'd0, mem_we}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_we_async", {31'd0, mem_we}, 0);
        check_eq("t6_no_rvalid", {31'd0, p1_rvalid}, 0);
        tick();
        check_eq("t6_no_rvalid2", {31'd0, p1_rvalid}, 0);
        check_eq("t6_rst_rdata", p0_rdata, 0);
        check_eq("t6_rst_addr", mem_addr, 0);
        #3;
        rst_n = 1'b1;
        tick();
        check_eq("t6_no_rvalid3", {31'd0, p1_rvalid}, 0);
        p0_req = 1; p0_addr = 32'h0; p0_memop = 3'b010; p0_we = 0;
        p1_req = 1; p1_addr = 32'h4; p1_memop = 3'b010; p1_we = 0;
        #1;
        check_eq("t6_tie_p0", {31'd0, p0_ready}, 1);
        check_eq("t6_tie_p1", {31'd0, p1_ready}, 0);
        tick();
        p0_req = 0; p1_req = 0;
        tick();
        check_eq("t6_p0_rdata", p0_rdata, 32'h1111_1111);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
